// File: rtl/sap1_datapath_if.sv
// SAP-1 datapath interface: control word and program-load port in,
// opcode, output register, bus debug and flags out.
interface sap1_datapath_if #(
    parameter int unsigned DATA_W = 8
);
    logic [11:0]       control_signal;
    logic              prog_we;
    logic [3:0]        prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] out_port;
    logic [DATA_W-1:0] bus_dbg;
    logic              bus_conflict;
    logic              carry_flag;
    logic              zero_flag;

    // Control unit / bench side
    modport master (
        output control_signal, prog_we, prog_addr, prog_data,
        input  opcode, out_port, bus_dbg, bus_conflict, carry_flag, zero_flag
    );

    // Datapath side
    modport slave (
        input  control_signal, prog_we, prog_addr, prog_data,
        output opcode, out_port, bus_dbg, bus_conflict, carry_flag, zero_flag
    );
endinterface

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, A, B, ALU and output register on a
// shared W-bus, fully sequenced by the 12-bit control word.
// Optional ALU flags are enabled by defining SAP1_FLAGS_EN.
module sap1_datapath #(
    parameter int unsigned RAM_DEPTH = 16,
    parameter int unsigned DATA_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    sap1_datapath_if.slave   bus_if
);
    // Control word {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}, normalised to active-high
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
    assign cp = bus_if.control_signal[11];
    assign ep = bus_if.control_signal[10];
    assign lm = ~bus_if.control_signal[9];
    assign ce = ~bus_if.control_signal[8];
    assign li = ~bus_if.control_signal[7];
    assign ei = ~bus_if.control_signal[6];
    assign la = ~bus_if.control_signal[5];
    assign ea = bus_if.control_signal[4];
    assign su = bus_if.control_signal[3];
    assign eu = bus_if.control_signal[2];
    assign lb = ~bus_if.control_signal[1];
    assign lo = ~bus_if.control_signal[0];

    logic [3:0]        pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
    logic [DATA_W-1:0] ram_q [RAM_DEPTH];
    logic [DATA_W-1:0] ram_rd, alu_res, bus;
    logic [4:0]        drv;

    assign ram_rd = ram_q[mar_q];

`ifdef SAP1_FLAGS_EN
    logic [DATA_W:0] alu_full;
    logic            carry_q, carry_d, zero_q, zero_d;

    // ALU with carry-out; subtract as A + ~B + 1 so carry means no borrow
    always_comb begin
        if (su) begin
            alu_full = {1'b0, a_q} + {1'b0, ~b_q} + {{DATA_W{1'b0}}, 1'b1};
        end else begin
            alu_full = {1'b0, a_q} + {1'b0, b_q};
        end
    end
    assign alu_res = alu_full[DATA_W-1:0];

    // Flags follow the ALU whenever its result is loaded into A
    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (reset) begin
            carry_d = 1'b0;
            zero_d  = 1'b0;
        end else if (la && eu) begin
            carry_d = alu_full[DATA_W];
            zero_d  = (alu_res == '0);
        end
    end

    // Flag registers
    always_ff @(posedge clk) begin
        carry_q <= carry_d;
        zero_q  <= zero_d;
    end

    assign bus_if.carry_flag = carry_q;
    assign bus_if.zero_flag  = zero_q;
`else
    // Plain modulo-2^DATA_W ALU, no flags
    always_comb begin
        alu_res = su ? (a_q - b_q) : (a_q + b_q);
    end

    assign bus_if.carry_flag = 1'b0;
    assign bus_if.zero_flag  = 1'b0;
`endif

    // W-bus: fixed priority Ep > RAM > IR > A > ALU; conflict if >1 driver
    always_comb begin
        drv = {ep, ce, ei, ea, eu};
        bus = '0;
        if (ep) begin
            bus = {{(DATA_W-4){1'b0}}, pc_q};
        end else if (ce) begin
            bus = ram_rd;
        end else if (ei) begin
            bus = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
        end else if (ea) begin
            bus = a_q;
        end else if (eu) begin
            bus = alu_res;
        end
    end

    // Register next-state; every load samples the same pre-edge bus, reset wins
    always_comb begin
        pc_d  = pc_q;
        mar_d = mar_q;
        ir_d  = ir_q;
        a_d   = a_q;
        b_d   = b_q;
        out_d = out_q;
        if (reset) begin
            pc_d  = '0;
            mar_d = '0;
            ir_d  = '0;
            a_d   = '0;
            b_d   = '0;
            out_d = '0;
        end else begin
            if (cp) pc_d  = pc_q + 4'd1;
            if (lm) mar_d = bus[3:0];
            if (li) ir_d  = bus;
            if (la) a_d   = bus;
            if (lb) b_d   = bus;
            if (lo) out_d = bus;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        pc_q  <= pc_d;
        mar_q <= mar_d;
        ir_q  <= ir_d;
        a_q   <= a_d;
        b_q   <= b_d;
        out_q <= out_d;
    end

    // Program RAM: written only from the load port, not cleared by reset
    always_ff @(posedge clk) begin
        if (bus_if.prog_we) begin
            ram_q[bus_if.prog_addr] <= bus_if.prog_data;
        end
    end

    assign bus_if.opcode       = ir_q[DATA_W-1:DATA_W-4];
    assign bus_if.out_port     = out_q;
    assign bus_if.bus_dbg      = bus;
    assign bus_if.bus_conflict = ((drv & (drv - 5'd1)) != 5'd0);

endmodule

// File: doc/sap1_datapath.md
Name: sap1_datapath

Overview:
Execution side of the SAP-1 control interface. It consumes the 12-bit control word from the control unit and carries out every bus transfer: PC, MAR, RAM, IR, A, B, ALU and output register on a shared 8-bit W-bus. It returns the opcode (IR[7:4]) to the control unit. It has a program-load port for the 16x8 RAM.

Parameters:
RAM_DEPTH, 16, RAM words; address width fixed at 4 bits.
DATA_W, 8, bus, register and RAM word width.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
control_signal  input  12  control word {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}, bit 11 = Cp.
prog_we  input  1  RAM write strobe.
prog_addr  input  4  RAM write address.
prog_data  input  8  RAM write data.
opcode  output  4  IR[7:4], returned to the control unit.
out_port  output  8  output register.
bus_dbg  output  8  current W-bus value.
bus_conflict  output  1  more than one bus driver enabled (combinational).
carry_flag  output  1  ALU carry; feature-dependent.
zero_flag  output  1  ALU zero; feature-dependent.

Behaviour:
- Control word changes on the control unit's negedge. Datapath samples on posedge, which gives a half-cycle setup.
- Bus drivers (enable, value):
  - Ep=1 -> {4'h0, PC}
  - CE_n=0 -> RAM[MAR]
  - Ei_n=0 -> {4'h0, IR[3:0]}
  - Ea=1 -> A
  - Eu=1 -> ALU
- Multiple drivers resolve by fixed priority Ep > RAM > IR > A > ALU, and bus_conflict=1. No driver: bus=8'h00, bus_conflict=0.
- ALU is combinational. Su=0 gives A+B, Su=1 gives A-B, both modulo 256.
- Posedge actions. All are independent and all use the same pre-edge bus value:
  - Cp=1: PC<=PC+1, wrapping 4'hF->4'h0.
  - Lm_n=0: MAR<=bus[3:0].
  - Li_n=0: IR<=bus.
  - La_n=0: A<=bus.
  - Lb_n=0: B<=bus.
  - Lo_n=0: OUT<=bus.
- Idle word 12'h3e3 changes no state.
- RAM:
  - Written only through the prog port: prog_we=1 writes prog_data to RAM[prog_addr] at posedge.
  - Read is asynchronous on MAR.
  - A write to the address being read is visible on the bus after the edge.
- Reset:
  - PC, MAR, IR, A, B, OUT and flags go to 0 at the next posedge. Outputs are then opcode=0 and out_port=0.
  - Reset has priority over every control action.
  - RAM contents are not cleared. prog_we is still honoured during reset, so a program can be loaded while the core is held in reset.
- Reset mid-instruction: the datapath clears while the control unit resyncs independently. No partial state survives.
- There is no internal sequencing state. All sequencing is in the control word, so the datapath is fully driven by control_signal.

Optional Feature:
- Macro SAP1_FLAGS_EN.
- Defined:
  - carry_flag and zero_flag update on any posedge with La_n=0 and Eu=1 (ALU result written to A).
  - carry = add carry-out, or no-borrow (A>=B) for subtract.
  - zero = (result==0).
  - Flags hold otherwise and reset to 0.
- Undefined: both ports are tied to 0 and no flag logic is present.

Test Plan:
1. Preload PC=5, A=0x33, OUT=0x44, then reset=1 for one edge -> PC=0, A=0, out_port=0x00, opcode=0. RAM[3] keeps its earlier value.
2. Fetch: RAM[0]=0x1A, PC=0, drive 5e3, be3, 263 on successive edges -> MAR=0, PC=1, IR=0x1A, opcode=4'h1.
3. Full program with control_unit attached:
   - Load RAM 0:0x09, 1:0x1A, 2:0x2B, 3:0xE0, 4:0xF0, 9:0x10, A:0x14, B:0x18.
   - Run 24 clocks -> out_port=0x0C.
4. ALU edge cases (SAP1_FLAGS_EN):
   - A=0xF0, B=0x20, add via 3c7 -> A=0x10, carry=1, zero=0.
   - A=0x05, B=0x07, sub via 3cf -> A=0xFE, carry=0.
   - A=B=0x22, sub -> A=0x00, zero=1.
5. PC wrap: PC=0xF, drive be3 -> PC=0x0.
6. Bus conflict:
   - Drive 5a3 with PC=2, RAM[MAR]=0x77 -> bus_dbg=0x02, bus_conflict=1, MAR<=2.
   - Drive 3e3 -> bus_dbg=0x00, bus_conflict=0.
